// File: rtl/lane_serializer.sv
// Parallel-to-serial lane transmitter: WIDTH-bit words in, one bit per beat out, LSB first.
// Optional even-parity trailer beat when PARITY_EN is defined.
module lane_serializer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_data,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {StIdle = 2'd0, StShift = 2'd1, StPar = 2'd2} state_e;
`else
    typedef enum logic [0:0] {StIdle = 1'b0, StShift = 1'b1} state_e;
`endif

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              shift_en;
    logic              load;
    logic              accept;
`ifdef PARITY_EN
    logic              par_q, par_d;
`endif

    always_comb begin
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        ser_first = 1'b0;
        ser_last  = 1'b0;
        shift_en  = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        case (state_q)
            StShift: begin
                ser_valid = 1'b1;
                ser_data  = shift_q[0];
                ser_first = (cnt_q == '0);
`ifndef PARITY_EN
                ser_last  = (cnt_q == LastCnt);
`endif
                if (ser_ready) begin
                    shift_en = 1'b1;
                    if (cnt_q == LastCnt) begin
`ifdef PARITY_EN
                        state_d = StPar;
                        cnt_d   = cnt_q + CW'(1);
`else
                        state_d = StIdle;
                        cnt_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`ifdef PARITY_EN
            StPar: begin
                ser_valid = 1'b1;
                ser_data  = par_q;
                ser_last  = 1'b1;
                if (ser_ready) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
`endif
            default: ;
        endcase

        // Refill from the holding buffer when idle or on the handshake of the terminal beat.
        load = hold_full_q && ((state_q == StIdle) || (ser_valid && ser_ready && ser_last));
        if (load) begin
            state_d = StShift;
            cnt_d   = '0;
        end

        accept      = in_valid && in_ready;
        hold_d      = accept ? in_data : hold_q;
        hold_full_d = accept ? 1'b1 : (load ? 1'b0 : hold_full_q);
    end

`ifdef PARITY_EN
    always_comb begin
        par_d = par_q;
        if (load) begin
            par_d = 1'b0;
        end else if (shift_en) begin
            par_d = par_q ^ shift_q[0];
        end
    end
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic upper;
        if (i == WIDTH - 1) begin : g_top
            assign upper = 1'b0;
        end else begin : g_mid
            assign upper = shift_q[i+1];
        end
        assign shift_d[i] = load ? hold_q[i] : (shift_en ? upper : shift_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign in_ready = !hold_full_q;
    assign busy     = (state_q != StIdle) || hold_full_q;

endmodule

// File: tb/tb_lane_serializer.sv
// Self-checking bench for lane_serializer: beat-level reference model plus literal frame checks.
module tb_lane_serializer;

    localparam int W = 4;
`ifdef PARITY_EN
    localparam int NB = W + 1;
    localparam string SeqA  = "01010";
    localparam string Seq3C = "1100000110";
    localparam string Seq5  = "10100";
    localparam string Seq7  = "11101";
    localparam string Seq1  = "10001";
`else
    localparam int NB = W;
    localparam string SeqA  = "0101";
    localparam string Seq3C = "11000011";
    localparam string Seq5  = "1010";
    localparam string Seq7  = "1110";
    localparam string Seq1  = "1000";
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         ser_valid;
    logic         ser_ready = 1'b0;
    logic         ser_data;
    logic         ser_first;
    logic         ser_last;
    logic         busy;

    always #5 clk = ~clk;

    lane_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_data  (ser_data),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a frame in the shifter (word + beat index) and a one-word holding slot.
    bit           m_active = 1'b0;
    bit           m_hold   = 1'b0;
    logic [W-1:0] m_word   = '0;
    logic [W-1:0] m_holdw  = '0;
    int           m_beat   = 0;
    bit           m_acc, m_bt, m_term, m_load;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 1'b0;
            m_hold   = 1'b0;
            m_beat   = 0;
        end else begin
            m_acc  = in_valid && !m_hold;
            m_bt   = m_active && ser_ready;
            m_term = m_bt && (m_beat == NB - 1);
            m_load = m_hold && (!m_active || m_term);
            if (m_bt) m_beat++;
            if (m_term) m_active = 1'b0;
            if (m_load) begin
                m_word   = m_holdw;
                m_beat   = 0;
                m_active = 1'b1;
                m_hold   = 1'b0;
            end
            if (m_acc) begin
                m_hold  = 1'b1;
                m_holdw = in_data;
            end
        end
    end

    typedef struct {
        logic d;
        logic f;
        logic l;
        int   cyc;
    } beat_t;

    beat_t blog[$];
    int    cyc     = 0;
    int    acc_cnt = 0;
    bit    chk_en  = 1'b0;
    logic  exp_d;

    // Compare process: every cycle out of reset, DUT outputs against the model.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst_n && chk_en) begin
            exp_d = !m_active ? 1'b0 : (m_beat < W ? m_word[m_beat] : ^m_word);
            chk("in_ready", in_ready, !m_hold);
            chk("ser_valid", ser_valid, m_active);
            chk("busy", busy, m_active || m_hold);
            chk("ser_data", ser_data, exp_d);
            chk("ser_first", ser_first, m_active && m_beat == 0);
            chk("ser_last", ser_last, m_active && m_beat == NB - 1);
            if (ser_valid && ser_ready) blog.push_back('{ser_data, ser_first, ser_last, cyc});
            if (in_valid && in_ready) acc_cnt++;
        end
    end

    task automatic send_word(input logic [W-1:0] w);
        bit rdy = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        in_valid = 1'b0;
        chk("send accepted", rdy, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle reached", busy, 1'b0);
    endtask

    task automatic check_log(input string name, input string exp, input bit contig);
        chk({name, " len"}, blog.size(), exp.len());
        for (int k = 0; k < exp.len() && k < blog.size(); k++) begin
            chk({name, " data"}, blog[k].d, exp[k] == 8'h31);
            chk({name, " first"}, blog[k].f, (k % NB) == 0);
            chk({name, " last"}, blog[k].l, (k % NB) == NB - 1);
            if (contig && k > 0) chk({name, " gap"}, blog[k].cyc - blog[k-1].cyc, 1);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, " in_ready"}, in_ready, 1'b1);
        chk({name, " ser_valid"}, ser_valid, 1'b0);
        chk({name, " ser_data"}, ser_data, 1'b0);
        chk({name, " ser_first"}, ser_first, 1'b0);
        chk({name, " ser_last"}, ser_last, 1'b0);
        chk({name, " busy"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en    = 1'b1;
        ser_ready = 1'b1;

        // Single word, latency and in_ready timing.
        blog.delete();
        send_word(4'hA);
        chk("accept in_ready", in_ready, 1'b0);
        chk("pre-load ser_valid", ser_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("first beat valid", ser_valid, 1'b1);
        chk("first beat first", ser_first, 1'b1);
        chk("load in_ready", in_ready, 1'b1);
        wait_idle();
        check_log("hA", SeqA, 1'b1);

        // Back-to-back words, no gap.
        blog.delete();
        send_word(4'h3);
        send_word(4'hC);
        chk("hold full in_ready", in_ready, 1'b0);
        wait_idle();
        check_log("h3hC", Seq3C, 1'b1);

        // Stall on beat 1.
        blog.delete();
        send_word(4'h5);
        n = 0;
        while (blog.size() < 1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        ser_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall valid", ser_valid, 1'b1);
            chk("stall data", ser_data, 1'b0);
            chk("stall first", ser_first, 1'b0);
            @(posedge clk);
            #1;
        end
        ser_ready = 1'b1;
        wait_idle();
        check_log("h5", Seq5, 1'b0);

        blog.delete();
        send_word(4'h7);
        wait_idle();
        check_log("h7", Seq7, 1'b1);

        // Reset mid-frame with a second word held.
        blog.delete();
        send_word(4'hF);
        send_word(4'h9);
        n = 0;
        while (blog.size() < 2 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid hold full", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        blog.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("post reset beats", blog.size(), 0);
        chk("post reset in_ready", in_ready, 1'b1);
        send_word(4'h1);
        wait_idle();
        check_log("h1", Seq1, 1'b1);

        // Downstream blocked: only shifter and hold take words.
        ser_ready = 1'b0;
        acc_cnt   = 0;
        in_valid  = 1'b1;
        in_data   = 4'h6;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("blocked accepts", acc_cnt, 2);
        chk("blocked in_ready", in_ready, 1'b0);
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("resume in_ready", in_ready, 1'b0);
        wait_idle();

        // Random traffic against the model.
        repeat (400) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            ser_ready = ($urandom % 4) != 0;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
